// File: rtl/change_event_fifo_if.sv
// Change-event FIFO bus: producer strobe/data, consumer valid/ready handshake,
// occupancy and sticky overflow status.
// Optional: CHANGE_EVENT_FIFO_TIMESTAMP_EN adds the out_ts timestamp signal.
interface change_event_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    logic                       pulse_in;
    logic [DATA_W-1:0]          data_in;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_data;
    logic [$clog2(DEPTH):0]     count;
    logic                       overflow;
    logic                       clr_overflow;
`ifdef CHANGE_EVENT_FIFO_TIMESTAMP_EN
    logic [15:0]                out_ts;
`endif

    // FIFO side
    modport slave (
        input  pulse_in, data_in, out_ready, clr_overflow,
        output out_valid, out_data, count, overflow
`ifdef CHANGE_EVENT_FIFO_TIMESTAMP_EN
        , output out_ts
`endif
    );

    // Producer/consumer side
    modport master (
        output pulse_in, data_in, out_ready, clr_overflow,
        input  out_valid, out_data, count, overflow
`ifdef CHANGE_EVENT_FIFO_TIMESTAMP_EN
        , input out_ts
`endif
    );
endinterface

// File: rtl/change_event_fifo.sv
// Change-event FIFO: captures data_in on every pulse_in strobe, presents the
// oldest entry show-ahead with valid/ready, flags dropped events (sticky).
// Optional: CHANGE_EVENT_FIFO_TIMESTAMP_EN stores a 16-bit cycle timestamp
// with each entry and shows it on out_ts.
module change_event_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    change_event_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              valid_q;
    logic              overflow_q;
    logic              full;
    logic              push;
    logic              pop;
    logic              push_ok;
    logic              drop;

`ifdef CHANGE_EVENT_FIFO_TIMESTAMP_EN
    logic [15:0]       ts_cnt;
    logic [15:0]       ts_mem [DEPTH];
`endif

    // Push/pop qualification and next occupancy
    always_comb begin
        full     = (cnt == CNT_W'(DEPTH));
        push     = bus.pulse_in;
        pop      = valid_q & bus.out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok  = push & (~full | pop);
        drop     = push & full & ~pop;
        cnt_next = cnt;
        case ({push_ok, pop})
            2'b10:   cnt_next = cnt + CNT_W'(1);
            2'b01:   cnt_next = cnt - CNT_W'(1);
            default: cnt_next = cnt;
        endcase
    end

    // Storage, pointers, occupancy, valid and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= bus.data_in;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt     <= cnt_next;
            valid_q <= (cnt_next != '0);
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

`ifdef CHANGE_EVENT_FIFO_TIMESTAMP_EN
    // Free-running cycle counter and per-entry timestamp capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ts_mem[i] <= '0;
            end
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
            if (push_ok) begin
                ts_mem[wr_ptr] <= ts_cnt;
            end
        end
    end

    assign bus.out_ts = ts_mem[rd_ptr];
`endif

    assign bus.out_valid = valid_q;
    assign bus.out_data  = mem[rd_ptr];
    assign bus.count     = cnt;
    assign bus.overflow  = overflow_q;
endmodule

// File: doc/change_event_fifo.md
Name: change_event_fifo

Overview:
- Consumer side of the change-pulse interface: on each single-cycle change pulse, captures the accompanying data word into a small FIFO.
- Presents captured words downstream with a valid/ready handshake.
- Sits between the change detectors (switch/pattern-select inputs) and the slower VGA control logic, so no change event is lost while the consumer is busy.
- Reports overflow with a sticky flag.

Parameters:
- DATA_W, 8, width of captured data word.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- pulse_in  input  1  change event strobe; one push request per high cycle.
- data_in  input  DATA_W  value captured when pulse_in=1.
- out_valid  output  1  FIFO non-empty; out_data holds oldest entry.
- out_ready  input  1  consumer accepts entry when out_valid=1.
- out_data  output  DATA_W  oldest entry (show-ahead).
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: an event was dropped.
- clr_overflow  input  1  clears overflow.

Behaviour:
Reset and storage
- rst_n sampled on rising clk only. While low: write/read pointers=0, count=0, out_valid=0, overflow=0, all storage=0, so out_data=0.
- Reset mid-operation discards all entries in the same cycle; pulse_in is ignored during reset.
- Storage: DEPTH x DATA_W registers; write/read pointers of $clog2(DEPTH) bits; pointers wrap modulo DEPTH naturally.
- count is held as a registered counter, not derived from pointers.

Push, pop and latency
- push = pulse_in. pop = out_valid & out_ready.
- Push stores data_in at wr_ptr, then wr_ptr++.
- Pop advances rd_ptr++.
- Push-to-visible latency is 1 cycle: a push at cycle N into an empty FIFO gives out_valid=1 and out_data=data_in(N) at N+1.
- out_valid = (count != 0), registered-equivalent; out_data = mem[rd_ptr]; out_data is not required to be stable while out_valid=0.
- count next = count + push_accepted - pop.

Boundary conditions
- Empty with pulse_in=1: pop is impossible since out_valid=0; entry is written and count becomes 1.
- Full (count=DEPTH), push with no pop: data_in is dropped; pointers and count unchanged; overflow set next cycle.
- Full, push and pop in the same cycle: both occur; count stays DEPTH; no overflow.
- Non-full, push and pop in the same cycle: both occur; count unchanged.
- out_ready=1 while out_valid=0: ignored, no pointer movement.
- overflow: set on a dropped push, cleared by clr_overflow; if set and clear coincide, set wins (overflow=1).
- Consumer contract: out_data and out_valid must not change while out_valid=1 and out_ready=0, except through reset.

Optional Feature:
- Macro CHANGE_EVENT_FIFO_TIMESTAMP_EN.
- Defined:
  - Adds a free-running 16-bit cycle counter, reset to 0, incrementing every cycle and wrapping 0xFFFF->0x0000.
  - Each accepted push also stores the counter value of the push cycle.
  - New output port out_ts (output, 16 bits) shows the timestamp of the oldest entry, aligned with out_data; reset value 0.
  - Dropped pushes store nothing.
- Not defined: no counter, no out_ts port, no timestamp storage; all other behaviour identical.

Test Plan:
1. Reset then idle -> out_valid=0, count=0, overflow=0, out_data=0x00; rst_n low mid-run with 3 entries -> next cycle count=0, out_valid=0.
2. Single pulse with data_in=0xA5 at cycle N, out_ready=0 -> N+1: out_valid=1, out_data=0xA5, count=1; out_ready=1 for one cycle -> out_valid=0, count=0.
3. Pulses with data_in 0x01,0x02,0x03,0x04,0x05 on consecutive cycles, out_ready=0 (DEPTH=4) -> count=4, overflow=1 after 5th; drain yields 0x01..0x04 in order, 0x05 absent.
4. Full FIFO, pulse_in=1 with 0x77 and out_ready=1 in the same cycle -> count stays 4, overflow stays 0, 0x77 is the last entry drained.
5. overflow=1; clr_overflow=1 in the same cycle as another dropped push -> overflow remains 1; clr_overflow alone next cycle -> overflow=0.
6. With CHANGE_EVENT_FIFO_TIMESTAMP_EN: reset, pulse at cycles 10 and 20 (counter 10, 20) -> out_ts reads 10 then 20 on successive pops; 70000 continuous idle cycles -> counter wraps, a push at counter value 0x0003 reports out_ts=0x0003.
